onchip_mem_reader: RTL and testbench

Avalon-MM read master that sits directly downstream of the 32-bit single-port on-chip memory (5320 words, 1-cycle read latency). On a command it reads a contiguous block of words and delivers them in order on a valid/ready stream with a last-word flag. It is the feed stage between the on-chip memory and the stream consumers of the console datapath.

---
 rtl/onchip_mem_reader_pkg.sv | 12 +
 rtl/onchip_mem_reader_if.sv | 43 ++++
 rtl/onchip_mem_reader_fifo.sv | 60 ++++++
 rtl/onchip_mem_reader.sv | 120 ++++++++++++
 tb/tb_onchip_mem_reader.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_mem_reader_pkg.sv
// Shared sizing constants and FSM state encodings for the on-chip memory read master.
package onchip_mem_reader_pkg;

    localparam int ADDR_W_C    = 13;
    localparam int DATA_W_C    = 32;
    localparam int MEM_DEPTH_C = 5320;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/onchip_mem_reader_if.sv
// Command, Avalon-MM read and output stream signals of the reader, bundled with
// the reader (master) and environment (slave) views.
interface onchip_mem_reader_if
    import onchip_mem_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_C,
    parameter int DATA_W = DATA_W_C
);

    logic              cmd_start;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W:0]   cmd_len;
    logic              cmd_busy;
    logic              cmd_done;
    logic              cmd_error;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        input  cmd_start, cmd_addr, cmd_len, mem_readdata, out_ready,
        output cmd_busy, cmd_done, cmd_error,
               mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
               out_valid, out_data, out_last
    );

    modport slave (
        output cmd_start, cmd_addr, cmd_len, mem_readdata, out_ready,
        input  cmd_busy, cmd_done, cmd_error,
               mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
               out_valid, out_data, out_last
    );

endinterface

// File: rtl/onchip_mem_reader_fifo.sv
// Show-ahead FIFO buffering returned read words; the head entry is visible on
// o_pop_data whenever the FIFO is non-empty.
module onchip_mem_reader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_pop_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty    = (r_count == '0);
    assign w_full     = (r_count == (PTR_W+1)'(DEPTH));
    assign w_do_pop   = i_pop && !o_empty;
    assign w_do_push  = i_push && (!w_full || w_do_pop);
    assign o_count    = r_count;
    assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/onchip_mem_reader.sv
// Block read master: fetches a contiguous run of words from the 1-cycle-latency
// on-chip memory and streams them out in order with a last-word flag.
module onchip_mem_reader
    import onchip_mem_reader_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_C,
    parameter int DATA_W     = DATA_W_C,
    parameter int MEM_DEPTH  = MEM_DEPTH_C,
    parameter int FIFO_DEPTH = 4
) (
    input logic                 clk,
    input logic                 reset,
    onchip_mem_reader_if.master bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_done;
    logic              r_error;

    logic [ADDR_W+1:0] w_end;
    logic              w_too_long;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_pop;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_count;
    logic [DATA_W:0]   w_fifo_word;

    // End address is formed two bits wider so a block running past the top cannot wrap.
    assign w_end      = {2'b00, bus.cmd_addr} + {1'b0, bus.cmd_len};
    assign w_too_long = (w_end > (ADDR_W+2)'(MEM_DEPTH));

    // Buffered plus in-flight words never exceed the FIFO, so a push always has room.
    assign w_issue = !reset && (r_state == ST_RUN) && (r_remaining != '0) &&
                     ((int'(w_count) + int'(r_inflight)) < FIFO_DEPTH);
    assign w_last_issue = w_issue && (r_remaining == (ADDR_W+1)'(1));
    assign w_pop        = !w_fifo_empty && bus.out_ready;

    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_clken      = 1'b1;
    assign bus.mem_chipselect = w_issue;
    assign bus.mem_address    = w_issue ? r_addr : '0;

    assign bus.cmd_busy  = (r_state != ST_IDLE);
    assign bus.cmd_done  = r_done;
    assign bus.cmd_error = r_error;

    assign bus.out_valid = !w_fifo_empty;
    assign bus.out_data  = w_fifo_word[DATA_W-1:0];
    assign bus.out_last  = w_fifo_word[DATA_W];

    onchip_mem_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (r_inflight),
        .i_push_data ({r_inflight_last, bus.mem_readdata}),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_word),
        .o_empty     (w_fifo_empty),
        .o_count     (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_last_issue;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_start) begin
                        if (bus.cmd_len == '0) begin
                            r_done <= 1'b1;
                        end else if (w_too_long) begin
                            r_error <= 1'b1;
                        end else begin
                            r_addr      <= bus.cmd_addr;
                            r_remaining <= bus.cmd_len;
                            r_state     <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        r_addr      <= r_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        if (w_last_issue) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && bus.out_last) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_onchip_mem_reader.sv
// Directed self-checking bench for onchip_mem_reader against a preloaded
// 1-cycle-latency memory model (mem[i] = i + 0x1000).
module tb_onchip_mem_reader;
    import onchip_mem_reader_pkg::*;

    localparam int FIFO_D = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    onchip_mem_reader_if #(.ADDR_W(ADDR_W_C), .DATA_W(DATA_W_C)) bus ();

    onchip_mem_reader #(
        .ADDR_W     (ADDR_W_C),
        .DATA_W     (DATA_W_C),
        .MEM_DEPTH  (MEM_DEPTH_C),
        .FIFO_DEPTH (FIFO_D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [MEM_DEPTH_C];
    logic [31:0] r_rdata;

    initial begin
        for (int i = 0; i < MEM_DEPTH_C; i++) begin
            mem[i] = 32'h1000 + i;
        end
    end

    always @(posedge clk) begin
        if (bus.mem_chipselect === 1'b1) begin
            r_rdata <= mem[bus.mem_address];
        end
    end
    assign bus.mem_readdata = r_rdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor log, sampled mid-cycle; tasks take deltas against snapshots.
    logic [31:0] q_data [$];
    logic        q_last [$];
    int          q_cyc  [$];
    int          q_addr [$];
    int          cs_count   = 0;
    int          ov_count   = 0;
    int          done_count = 0;
    int          err_count  = 0;
    int          done_cyc   = -1;
    int          err_cyc    = -1;
    int          stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] held_data  = '0;
    logic        held_last  = 1'b0;

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            q_data.push_back(bus.out_data);
            q_last.push_back(bus.out_last);
            q_cyc.push_back(cyc);
        end
        if (bus.out_valid === 1'b1) ov_count <= ov_count + 1;
        if (prev_stall && reset !== 1'b1 &&
            (bus.out_valid !== 1'b1 || bus.out_data !== held_data || bus.out_last !== held_last)) begin
            stall_viol <= stall_viol + 1;
        end
        prev_stall <= (bus.out_valid === 1'b1 && bus.out_ready === 1'b0 && reset !== 1'b1);
        held_data  <= bus.out_data;
        held_last  <= bus.out_last;
        if (bus.mem_chipselect === 1'b1) begin
            cs_count <= cs_count + 1;
            q_addr.push_back(int'(bus.mem_address));
        end
        if (bus.cmd_done === 1'b1) begin
            done_count <= done_count + 1;
            done_cyc   <= cyc;
        end
        if (bus.cmd_error === 1'b1) begin
            err_count <= err_count + 1;
            err_cyc   <= cyc;
        end
    end

    task automatic run_cmd(input int addr, input int len, output int c0);
        bus.cmd_addr  = 13'(addr);
        bus.cmd_len   = 14'(len);
        bus.cmd_start = 1'b1;
        @(posedge clk); #1;
        bus.cmd_start = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_count == d0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (done_count == d0) begin
            failures++;
            $display("[TB] FAIL done_timeout got=none exp=cmd_done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin failures++; $display("[TB] FAIL rst_out_data got=%h exp=0", bus.out_data); end
        checks++; if (bus.cmd_busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%b exp=0", bus.cmd_busy); end
        checks++; if (bus.cmd_done !== 1'b0 || bus.cmd_error !== 1'b0) begin failures++; $display("[TB] FAIL rst_done_err got=%b%b exp=00", bus.cmd_done, bus.cmd_error); end
        checks++; if (bus.mem_chipselect !== 1'b0 || bus.mem_address !== 13'd0) begin failures++; $display("[TB] FAIL rst_mem got=cs%b addr%0d exp=cs0 addr0", bus.mem_chipselect, bus.mem_address); end
        checks++; if (bus.mem_byteenable !== 4'hF || bus.mem_clken !== 1'b1 || bus.mem_write !== 1'b0) begin failures++; $display("[TB] FAIL rst_const got=be%h clken%b wr%b exp=beF clken1 wr0", bus.mem_byteenable, bus.mem_clken, bus.mem_write); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int hs0, cs0, d0, c0;
        hs0 = q_data.size(); cs0 = cs_count; d0 = done_count;
        bus.out_ready = 1'b1;
        run_cmd(10, 5, c0);
        wait_done(d0, 40);
        checks++;
        if (q_data.size() - hs0 != 5) begin failures++; $display("[TB] FAIL basic_count got=%0d exp=5", q_data.size() - hs0); end
        for (int k = 0; k < 5 && hs0 + k < q_data.size(); k++) begin
            checks++;
            if (q_data[hs0+k] !== 32'h100A + k) begin failures++; $display("[TB] FAIL basic_data%0d got=%h exp=%h", k, q_data[hs0+k], 32'h100A + k); end
            checks++;
            if (q_cyc[hs0+k] != c0 + 2 + k) begin failures++; $display("[TB] FAIL basic_time%0d got=T0+%0d exp=T0+%0d", k, q_cyc[hs0+k] - c0 + 1, k + 3); end
            checks++;
            if (q_last[hs0+k] !== (k == 4)) begin failures++; $display("[TB] FAIL basic_last%0d got=%b exp=%b", k, q_last[hs0+k], (k == 4)); end
        end
        checks++;
        if (done_cyc != c0 + 7) begin failures++; $display("[TB] FAIL basic_done_time got=T0+%0d exp=T0+8", done_cyc - c0 + 1); end
        checks++;
        if (cs_count - cs0 != 5) begin failures++; $display("[TB] FAIL basic_reads got=%0d exp=5", cs_count - cs0); end
        checks++;
        if (bus.cmd_busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_after got=%b exp=0", bus.cmd_busy); end
    endtask

    task automatic test_backpressure();
        int hs0, cs0, d0, sv0, c0, outst, max_out;
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        hs0 = q_data.size(); cs0 = cs_count; d0 = done_count; sv0 = stall_viol;
        max_out = 0;
        run_cmd(10, 5, c0);
        for (int k = 0; k < 80 && done_count == d0; k++) begin
            bus.out_ready = pat[k % 4];
            outst = (cs_count - cs0) - (q_data.size() - hs0);
            if (outst > max_out) max_out = outst;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        wait_done(d0, 10);
        checks++;
        if (q_data.size() - hs0 != 5) begin failures++; $display("[TB] FAIL bp_count got=%0d exp=5", q_data.size() - hs0); end
        for (int k = 0; k < 5 && hs0 + k < q_data.size(); k++) begin
            checks++;
            if (q_data[hs0+k] !== 32'h100A + k || q_last[hs0+k] !== (k == 4)) begin
                failures++;
                $display("[TB] FAIL bp_word%0d got=%h/%b exp=%h/%b", k, q_data[hs0+k], q_last[hs0+k], 32'h100A + k, (k == 4));
            end
        end
        checks++;
        if (stall_viol != sv0) begin failures++; $display("[TB] FAIL bp_stable got=%0d violations exp=0", stall_viol - sv0); end
        checks++;
        if (max_out > FIFO_D + 1) begin failures++; $display("[TB] FAIL bp_outstanding got=%0d exp<=%0d", max_out, FIFO_D + 1); end
        checks++;
        if (cs_count - cs0 != 5) begin failures++; $display("[TB] FAIL bp_reads got=%0d exp=5", cs_count - cs0); end
    endtask

    task automatic test_last_address();
        int hs0, qa0, d0, c0, max_addr;
        hs0 = q_data.size(); qa0 = q_addr.size(); d0 = done_count;
        bus.out_ready = 1'b1;
        run_cmd(5315, 5, c0);
        wait_done(d0, 40);
        checks++;
        if (q_data.size() - hs0 != 5) begin failures++; $display("[TB] FAIL top_count got=%0d exp=5", q_data.size() - hs0); end
        for (int k = 0; k < 5 && hs0 + k < q_data.size(); k++) begin
            checks++;
            if (q_data[hs0+k] !== 32'h24C3 + k) begin failures++; $display("[TB] FAIL top_data%0d got=%h exp=%h", k, q_data[hs0+k], 32'h24C3 + k); end
        end
        max_addr = 0;
        for (int k = qa0; k < q_addr.size(); k++) begin
            if (q_addr[k] > max_addr) max_addr = q_addr[k];
        end
        checks++;
        if (max_addr != 5319) begin failures++; $display("[TB] FAIL top_max_addr got=%0d exp=5319", max_addr); end
        checks++;
        if (q_addr.size() - qa0 != 5) begin failures++; $display("[TB] FAIL top_reads got=%0d exp=5", q_addr.size() - qa0); end
    endtask

    task automatic test_overrun();
        int cs0, e0, d0, c0;
        cs0 = cs_count; e0 = err_count; d0 = done_count;
        run_cmd(5316, 5, c0);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (err_count - e0 != 1) begin failures++; $display("[TB] FAIL ovr_err_pulses got=%0d exp=1", err_count - e0); end
        checks++;
        if (err_cyc != c0) begin failures++; $display("[TB] FAIL ovr_err_time got=T0+%0d exp=T0+1", err_cyc - c0 + 1); end
        checks++;
        if (cs_count != cs0) begin failures++; $display("[TB] FAIL ovr_reads got=%0d exp=0", cs_count - cs0); end
        checks++;
        if (done_count != d0 || bus.cmd_busy !== 1'b0) begin failures++; $display("[TB] FAIL ovr_idle got=done%0d busy%b exp=done0 busy0", done_count - d0, bus.cmd_busy); end
    endtask

    task automatic test_zero_len();
        int cs0, d0, ov0, c0;
        cs0 = cs_count; d0 = done_count; ov0 = ov_count;
        run_cmd(50, 0, c0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done_count - d0 != 1) begin failures++; $display("[TB] FAIL zero_done_pulses got=%0d exp=1", done_count - d0); end
        checks++;
        if (done_cyc != c0) begin failures++; $display("[TB] FAIL zero_done_time got=T0+%0d exp=T0+1", done_cyc - c0 + 1); end
        checks++;
        if (cs_count != cs0 || ov_count != ov0) begin failures++; $display("[TB] FAIL zero_activity got=reads%0d valid%0d exp=0/0", cs_count - cs0, ov_count - ov0); end
    endtask

    task automatic test_reset_mid();
        int hs0, d0, c0;
        bus.out_ready = 1'b0;
        run_cmd(100, 8, c0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1064) begin failures++; $display("[TB] FAIL mid_head got=v%b %h exp=v1 00001064", bus.out_valid, bus.out_data); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.cmd_busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_flush got=v%b busy%b exp=v0 busy0", bus.out_valid, bus.cmd_busy); end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_inflight_dropped got=v%b exp=v0", bus.out_valid); end
        hs0 = q_data.size(); d0 = done_count;
        bus.out_ready = 1'b1;
        run_cmd(200, 3, c0);
        wait_done(d0, 40);
        checks++;
        if (q_data.size() - hs0 != 3) begin failures++; $display("[TB] FAIL mid_new_count got=%0d exp=3", q_data.size() - hs0); end
        for (int k = 0; k < 3 && hs0 + k < q_data.size(); k++) begin
            checks++;
            if (q_data[hs0+k] !== 32'h10C8 + k) begin failures++; $display("[TB] FAIL mid_new_data%0d got=%h exp=%h", k, q_data[hs0+k], 32'h10C8 + k); end
        end
    endtask

    task automatic test_busy_ignore();
        int hs0, qa0, d0, c0;
        hs0 = q_data.size(); qa0 = q_addr.size(); d0 = done_count;
        bus.out_ready = 1'b1;
        run_cmd(20, 4, c0);
        bus.cmd_addr  = 13'd300;
        bus.cmd_len   = 14'd2;
        bus.cmd_start = 1'b1;
        @(posedge clk); #1;
        bus.cmd_start = 1'b0;
        wait_done(d0, 40);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (q_data.size() - hs0 != 4) begin failures++; $display("[TB] FAIL busy_count got=%0d exp=4", q_data.size() - hs0); end
        for (int k = 0; k < 4 && hs0 + k < q_data.size(); k++) begin
            checks++;
            if (q_data[hs0+k] !== 32'h1014 + k) begin failures++; $display("[TB] FAIL busy_data%0d got=%h exp=%h", k, q_data[hs0+k], 32'h1014 + k); end
        end
        for (int k = 0; k < 4 && qa0 + k < q_addr.size(); k++) begin
            checks++;
            if (q_addr[qa0+k] != 20 + k) begin failures++; $display("[TB] FAIL busy_addr%0d got=%0d exp=%0d", k, q_addr[qa0+k], 20 + k); end
        end
        checks++;
        if (q_addr.size() - qa0 != 4 || done_count - d0 != 1) begin failures++; $display("[TB] FAIL busy_extra got=reads%0d done%0d exp=4/1", q_addr.size() - qa0, done_count - d0); end
    endtask

    initial begin
        reset         = 1'b1;
        bus.cmd_start = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_last_address();
        test_overrun();
        test_zero_len();
        test_reset_mid();
        test_busy_ignore();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=still running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
